// File: rtl/char_row_pkg.sv
// Shared types and helpers for the single-row character buffer.
package char_row_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_CHAR_W = 6;
    localparam logic [DEFAULT_CHAR_W-1:0] DEFAULT_BLANK_CODE = '1;

    // Ceiling log2, never below 1 so derived vectors always have a bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((r < 31) && ((32'd1 << r) < v)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/char_row_mem.sv
// Character storage: one write port, one registered read port, contents not reset.
module char_row_mem
    import char_row_pkg::*;
#(
    parameter int unsigned NUM_COLS = 16,
    parameter int unsigned CHAR_W   = DEFAULT_CHAR_W,
    parameter int unsigned AW       = clog2(NUM_COLS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [CHAR_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [CHAR_W-1:0] rdata
);

    logic [CHAR_W-1:0] mem_q [NUM_COLS];

    // Read samples the pre-write contents, giving old-data on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata <= mem_q[raddr];
    end

endmodule

// File: rtl/char_row_buffer.sv
// Single text row for the VGA path: 2-cycle pixel-to-character lookup plus write/clear engine.
// Optional blinking cursor output enabled by defining CHAR_ROW_CURSOR_EN.
module char_row_buffer
    import char_row_pkg::*;
#(
    parameter int unsigned       NUM_COLS   = 16,
    parameter int unsigned       CHAR_W     = DEFAULT_CHAR_W,
    parameter int unsigned       GLYPH_W    = 8,
    parameter int unsigned       GLYPH_H    = 10,
    parameter int unsigned       X_START    = 0,
    parameter int unsigned       Y_START    = 100,
    parameter logic [CHAR_W-1:0] BLANK_CODE = '1
`ifdef CHAR_ROW_CURSOR_EN
    ,
    parameter int unsigned       CURSOR_BLINK = 30
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [9:0]                  xcoor,
    input  logic [8:0]                  ycoor,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic                        wr_auto,
    input  logic [clog2(NUM_COLS)-1:0]  wr_addr,
    input  logic [CHAR_W-1:0]           wr_data,
    input  logic                        clr_req,
    output logic                        busy,
    output logic [CHAR_W-1:0]           char_out,
    output logic [clog2(GLYPH_W)-1:0]   glyph_x,
    output logic [clog2(GLYPH_H)-1:0]   glyph_y,
    output logic                        in_row
`ifdef CHAR_ROW_CURSOR_EN
    ,
    output logic                        cursor_hit
`endif
);

    localparam int unsigned COL_AW  = clog2(NUM_COLS);
    localparam int unsigned GX_W    = clog2(GLYPH_W);
    localparam int unsigned GY_W    = clog2(GLYPH_H);
    localparam int unsigned ROW_PIX = NUM_COLS * GLYPH_W;

    state_t              state_q, state_n;
    logic [COL_AW-1:0]   cnt_q, cnt_n;
    logic [COL_AW-1:0]   ptr_q, ptr_n;
    logic                mem_we;
    logic [COL_AW-1:0]   mem_waddr;
    logic [CHAR_W-1:0]   mem_wdata;
    logic [CHAR_W-1:0]   rd_data;
    logic                addr_ok_c;

    // Offsets carry an extra top bit so a coordinate left/above the row shows as negative.
    logic [10:0]         dx_c;
    logic [9:0]          dy_c;
    logic                in_c;
    logic [COL_AW-1:0]   col_c;

    logic                in_s1;
    logic [GX_W-1:0]     gx_s1;
    logic [GY_W-1:0]     gy_s1;

    assign dx_c  = {1'b0, xcoor} - 11'(X_START);
    assign dy_c  = {1'b0, ycoor} - 10'(Y_START);
    assign in_c  = !dx_c[10] && (dx_c < 11'(ROW_PIX)) && !dy_c[9] && (dy_c < 10'(GLYPH_H));
    assign col_c = dx_c[GX_W +: COL_AW];

    // Explicit addresses past the last column are dropped; only possible for non-power-of-two rows.
    if ((1 << COL_AW) == NUM_COLS) begin : g_addr_full
        assign addr_ok_c = 1'b1;
    end else begin : g_addr_chk
        assign addr_ok_c = (32'(wr_addr) < NUM_COLS);
    end

    char_row_mem #(
        .NUM_COLS (NUM_COLS),
        .CHAR_W   (CHAR_W),
        .AW       (COL_AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (col_c),
        .rdata (rd_data)
    );

    // Lookup pipeline: stage 1 alongside the memory read, stage 2 drives outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_s1    <= 1'b0;
            gx_s1    <= '0;
            gy_s1    <= '0;
            char_out <= BLANK_CODE;
            glyph_x  <= '0;
            glyph_y  <= '0;
            in_row   <= 1'b0;
        end else begin
            in_s1    <= in_c;
            gx_s1    <= in_c ? dx_c[GX_W-1:0] : '0;
            gy_s1    <= in_c ? dy_c[GY_W-1:0] : '0;
            char_out <= in_s1 ? rd_data : BLANK_CODE;
            glyph_x  <= gx_s1;
            glyph_y  <= gy_s1;
            in_row   <= in_s1;
        end
    end

    // Control state, sweep counter, write pointer and the registered handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            ptr_q    <= '0;
            busy     <= 1'b1;
            wr_ready <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            ptr_q    <= ptr_n;
            busy     <= (state_n != ST_IDLE);
            wr_ready <= (state_n == ST_IDLE);
        end
    end

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        ptr_n     = ptr_q;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = BLANK_CODE;
        case (state_q)
            ST_INIT, ST_CLEAR: begin
                mem_we = 1'b1;
                if (state_q == ST_INIT) begin
                    mem_wdata = CHAR_W'(cnt_q);
                end
                if (cnt_q == COL_AW'(NUM_COLS - 1)) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + COL_AW'(1);
                end
            end
            default: begin
                if (wr_valid && wr_ready) begin
                    mem_wdata = wr_data;
                    if (wr_auto) begin
                        mem_we    = 1'b1;
                        mem_waddr = ptr_q;
                        ptr_n     = (ptr_q == COL_AW'(NUM_COLS - 1)) ? '0 : ptr_q + COL_AW'(1);
                    end else begin
                        mem_we    = addr_ok_c;
                        mem_waddr = wr_addr;
                    end
                end
                // The same-cycle write lands first and is then blanked by the sweep.
                if (clr_req) begin
                    state_n = ST_CLEAR;
                    cnt_n   = '0;
                    ptr_n   = '0;
                end
            end
        endcase
        if (rst) begin
            mem_we = 1'b0;
        end
    end

`ifdef CHAR_ROW_CURSOR_EN
    localparam int unsigned BW = clog2(CURSOR_BLINK + 1);

    logic [COL_AW-1:0] col_s1;
    logic              frame_c;
    logic              frame_q;
    logic              phase_q;
    logic [BW-1:0]     blink_cnt_q;

    assign frame_c = (xcoor == 10'd0) && (ycoor == 9'd0);

    // Frame start counted on the first cycle at the origin; phase flips every CURSOR_BLINK frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_s1      <= '0;
            frame_q     <= 1'b0;
            phase_q     <= 1'b1;
            blink_cnt_q <= '0;
            cursor_hit  <= 1'b0;
        end else begin
            col_s1  <= col_c;
            frame_q <= frame_c;
            if (frame_c && !frame_q) begin
                if (blink_cnt_q == BW'(CURSOR_BLINK - 1)) begin
                    blink_cnt_q <= '0;
                    phase_q     <= !phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BW'(1);
                end
            end
            cursor_hit <= in_s1 && (col_s1 == ptr_q) && phase_q;
        end
    end
`endif

endmodule

// File: tb/tb_char_row_buffer.sv
// Directed and randomized bench for char_row_buffer against an array-based row model.
module tb_char_row_buffer;

    localparam int X_START = 0;
    localparam int Y_START = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x = 10'd600;
    logic [8:0] y = 9'd0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       wr_auto = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [5:0] wr_data = 6'd0;
    logic       clr_req = 1'b0;
    logic       busy;
    logic [5:0] char_out;
    logic [2:0] glyph_x;
    logic [3:0] glyph_y;
    logic       in_row;
`ifdef CHAR_ROW_CURSOR_EN
    logic       cursor_hit;
`endif

    int compared = 0;
    int mismatched = 0;

    // Reference model: row contents, pointer, remaining sweep length, and the lookup in flight.
    int m_mem[16];
    int m_ptr = 0;
    int sw_left = 0;
    int sw_col = 0;
    bit sw_clr = 1'b0;
    int p1_char = 63, p1_gx = 0, p1_gy = 0, p1_in = 0;

    char_row_buffer dut (
        .clk      (clk),
        .rst      (rst),
        .xcoor    (x),
        .ycoor    (y),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_auto  (wr_auto),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
        .busy     (busy),
        .char_out (char_out),
        .glyph_x  (glyph_x),
        .glyph_y  (glyph_y),
        .in_row   (in_row)
`ifdef CHAR_ROW_CURSOR_EN
        ,
        .cursor_hit (cursor_hit)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: predict the lookup, update the model for this edge, then compare all outputs.
    task automatic step();
        int dx, dy, e_in, e_char, e_gx, e_gy;
        dx = int'(x) - X_START;
        dy = int'(y) - Y_START;
        e_in   = (dx >= 0 && dx < 128 && dy >= 0 && dy < 10) ? 1 : 0;
        e_char = (e_in != 0) ? m_mem[dx / 8] : 63;
        e_gx   = (e_in != 0) ? dx % 8 : 0;
        e_gy   = (e_in != 0) ? dy : 0;
        if (rst) begin
            sw_left = 16; sw_col = 0; sw_clr = 1'b0; m_ptr = 0;
        end else if (sw_left > 0) begin
            m_mem[sw_col] = sw_clr ? 63 : sw_col % 64;
            sw_col++;
            sw_left--;
        end else begin
            if (wr_valid) begin
                if (wr_auto) begin
                    m_mem[m_ptr] = int'(wr_data);
                    m_ptr = (m_ptr + 1) % 16;
                end else begin
                    m_mem[int'(wr_addr)] = int'(wr_data);
                end
            end
            if (clr_req) begin
                sw_left = 16; sw_col = 0; sw_clr = 1'b1; m_ptr = 0;
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            check("char_out", 32'(char_out), 32'd63);
            check("glyph_x", 32'(glyph_x), 32'd0);
            check("glyph_y", 32'(glyph_y), 32'd0);
            check("in_row", 32'(in_row), 32'd0);
            p1_char = 63; p1_gx = 0; p1_gy = 0; p1_in = 0;
        end else begin
            check("char_out", 32'(char_out), 32'(p1_char));
            check("glyph_x", 32'(glyph_x), 32'(p1_gx));
            check("glyph_y", 32'(glyph_y), 32'(p1_gy));
            check("in_row", 32'(in_row), 32'(p1_in));
            p1_char = e_char; p1_gx = e_gx; p1_gy = e_gy; p1_in = e_in;
        end
        check("busy", 32'(busy), 32'(sw_left > 0));
        check("wr_ready", 32'(wr_ready), 32'(sw_left == 0));
    endtask

    task automatic look(input int col, output int code);
        x = 10'(X_START + col * 8 + 1);
        y = 9'(Y_START + 2);
        step();
        step();
        code = int'(char_out);
    endtask

    // Steps until the flag drops, counting cycles it was high (including the current one).
    task automatic count_busy(input string tag, output int n);
        n = 1;
        while (busy && n < 100) begin
            step();
            if (busy) n++;
        end
        if (n >= 100) check({tag, "_timeout"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n, code;
        foreach (m_mem[i]) m_mem[i] = 0;

        // Reset and INIT sweep length.
        rst = 1'b1;
        step();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        rst = 1'b0;
        count_busy("init", n);
        check("init_busy_len", 32'(n), 32'd16);

        // First lookup after INIT.
        x = 10'd17; y = 9'd103;
        step(); step();
        check("first_char", 32'(char_out), 32'd2);
        check("first_gx", 32'(glyph_x), 32'd1);
        check("first_gy", 32'(glyph_y), 32'd3);
        check("first_in", 32'(in_row), 32'd1);

        // Region boundaries.
        x = 10'd127; y = 9'd109;
        step(); step();
        check("edge_in", 32'(in_row), 32'd1);
        check("edge_char", 32'(char_out), 32'd15);
        x = 10'd128; y = 9'd109;
        step(); step();
        check("x128_in", 32'(in_row), 32'd0);
        check("x128_char", 32'(char_out), 32'h3F);
        x = 10'd5; y = 9'd110;
        step(); step();
        check("y110_in", 32'(in_row), 32'd0);
        check("y110_char", 32'(char_out), 32'h3F);
        x = 10'd5; y = 9'd99;
        step(); step();
        check("y99_in", 32'(in_row), 32'd0);
        check("y99_char", 32'(char_out), 32'h3F);

        // Read-during-write on column 3: old code first, new code one lookup later.
        x = 10'd65; y = 9'd101;
        step();
        x = 10'd25;
        wr_valid = 1'b1; wr_auto = 1'b0; wr_addr = 4'd3; wr_data = 6'h15;
        step();
        wr_valid = 1'b0;
        step();
        check("rdw_old", 32'(char_out), 32'd3);
        step();
        check("rdw_new", 32'(char_out), 32'h15);

        // Seventeen auto writes wrap the pointer.
        x = 10'd600; y = 9'd0;
        wr_auto = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_valid = 1'b1; wr_data = 6'(8'h20 + i);
            step();
        end
        wr_valid = 1'b0;
        look(0, code);  check("wrap_col0", 32'(code), 32'h30);
        look(1, code);  check("wrap_col1", 32'(code), 32'h21);
        look(15, code); check("wrap_col15", 32'(code), 32'h2F);
        wr_valid = 1'b1; wr_data = 6'h11;
        step();
        wr_valid = 1'b0;
        look(1, code);  check("ptr_after_wrap", 32'(code), 32'h11);

        // Plain clear.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        count_busy("clear", n);
        check("clear_len", 32'(n), 32'd16);
        for (int c = 0; c < 16; c++) begin
            look(c, code);
            check("clear_blank", 32'(code), 32'h3F);
        end
        wr_valid = 1'b1; wr_auto = 1'b1; wr_data = 6'h05;
        step();
        wr_valid = 1'b0;
        look(0, code); check("ptr_after_clear", 32'(code), 32'h05);

        // Write coinciding with clr_req is overwritten; a write held through the sweep lands after it.
        wr_valid = 1'b1; wr_auto = 1'b1; wr_data = 6'h22; clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        wr_auto = 1'b0; wr_addr = 4'd5; wr_data = 6'h0A;
        count_busy("clear2", n);
        check("clear2_len", 32'(n), 32'd16);
        step();
        wr_valid = 1'b0;
        look(1, code); check("clr_overwrite", 32'(code), 32'h3F);
        look(5, code); check("held_write", 32'(code), 32'h0A);
        look(4, code); check("held_neighbour", 32'(code), 32'h3F);

        // Reset in the middle of a sweep restarts INIT.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        x = 10'd600; y = 9'd0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy("rst_mid", n);
        check("rst_mid_len", 32'(n), 32'd16);
        look(7, code); check("reinit_col7", 32'(code), 32'd7);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            x = 10'($urandom_range(0, 180));
            y = 9'($urandom_range(95, 114));
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_auto  = 1'($urandom);
            wr_addr  = 4'($urandom);
            wr_data  = 6'($urandom);
            clr_req  = ($urandom_range(0, 60) == 0);
            step();
        end
        wr_valid = 1'b0; clr_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/char_row_buffer.md
Name: char_row_buffer

Overview:
- Parametrised single-row text buffer for the VGA text path.
- Holds NUM_COLS character codes written by the host-side interface.
- For each pixel coordinate it returns the character code under that pixel, plus the pixel's position inside the glyph cell, for the downstream font ROM.
- Next generation of the 16-column row block. Adds:
  - explicit and auto-increment writes with a ready handshake;
  - a sequenced clear/init engine;
  - a fixed 2-cycle pipelined lookup.

Parameters:
- NUM_COLS, 16, number of character cells in the row.
- CHAR_W, 6, character code width in bits.
- GLYPH_W, 8, cell width in pixels; must be a power of two.
- GLYPH_H, 10, cell height in pixels.
- X_START, 0, first pixel column of the row.
- Y_START, 100, first pixel line of the row.
- BLANK_CODE, all ones (CHAR_W bits), code output outside the row and written by clear.

Ports:
- clk  in  1  system pixel clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- xcoor  in  10  current pixel X, 0..639.
- ycoor  in  9  current pixel Y, 0..479.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_auto  in  1  1 = write at internal pointer; 0 = write at wr_addr.
- wr_addr  in  COL_AW  explicit column (COL_AW = clog2(NUM_COLS)).
- wr_data  in  CHAR_W  character code to store.
- clr_req  in  1  one-cycle pulse: start blanking the whole row.
- busy  out  1  init/clear sweep in progress.
- char_out  out  CHAR_W  code for the pixel presented 2 cycles earlier.
- glyph_x  out  clog2(GLYPH_W)  pixel column within the cell.
- glyph_y  out  clog2(GLYPH_H)  pixel line within the cell.
- in_row  out  1  pixel lies inside the row region.

Behaviour:
- Region test:
  - X_START <= xcoor < X_START + NUM_COLS*GLYPH_W, and
  - Y_START <= ycoor < Y_START + GLYPH_H.
  - Boundaries are half-open: exactly NUM_COLS*GLYPH_W pixels by GLYPH_H lines.
- Stage 1 (registered):
  - dx = xcoor - X_START, dy = ycoor - Y_START.
  - col = dx >> log2(GLYPH_W); glyph_x = dx low bits; glyph_y = dy (no divider).
  - Stage-1 in_row flag computed from the region test.
- Stage 2 (registered):
  - char_out = mem[col] when in_row, else BLANK_CODE.
  - glyph_x, glyph_y and in_row forwarded.
  - Outside the region glyph_x and glyph_y are forced to 0.
- Latency: exactly 2 clk from coordinates to all outputs. No stall; the pipeline runs every cycle.
- Read-during-write to the same column returns the old code. The new code is visible to a lookup presented one cycle after the write.
- State machine:
  - IDLE: wr_ready = 1, busy = 0.
  - INIT: entered on rst. Sweeps col 0..NUM_COLS-1, one per cycle, writing identity pattern i mod 2^CHAR_W. Returns to IDLE after the last column.
  - CLEAR: entered from IDLE on clr_req. Same sweep, writing BLANK_CODE. Resets the write pointer to 0. Returns to IDLE.
  - A sweep takes exactly NUM_COLS cycles; busy = 1 and wr_ready = 0 throughout.
  - clr_req while busy is ignored.
- Reset values:
  - char_out = BLANK_CODE; glyph_x = glyph_y = 0; in_row = 0.
  - wr_ptr = 0; state = INIT; busy = 1; wr_ready = 0.
  - rst asserted mid-sweep restarts INIT from column 0.
- Writes:
  - Accepted write stores wr_data at wr_ptr (wr_auto = 1) or at wr_addr (wr_auto = 0).
  - wr_ptr increments only on accepted auto writes, wrapping NUM_COLS-1 -> 0.
  - wr_addr >= NUM_COLS: write is accepted and discarded; wr_ptr unchanged.
- Simultaneous wr_valid and clr_req in IDLE: the write is performed that cycle, then CLEAR starts next cycle, so the write is overwritten.
- Lookups during a sweep return current memory contents (partially cleared rows are visible).

Optional Feature:
- Macro: CHAR_ROW_CURSOR_EN.
- Defined:
  - Adds parameter CURSOR_BLINK (default 30) and output cursor_hit (1 bit), aligned with char_out.
  - A frame start is xcoor == 0 && ycoor == 0, counted once per frame.
  - Every CURSOR_BLINK frames a blink phase bit toggles; phase resets to 1.
  - cursor_hit = in_row && stage-2 col == wr_ptr && phase.
- Undefined: port, parameter, counter and logic are absent.

Decomposition:
- Package char_row_pkg: state enum (IDLE/INIT/CLEAR), clog2 helper function, default BLANK_CODE constant.
- Sub-module char_row_mem:
  - NUM_COLS x CHAR_W register array, one write port, one registered read port.
  - Instantiated once; no reset on its contents.

Test Plan:
- Reset 1 cycle, release, wait for busy to drop:
  - busy high exactly 16 cycles;
  - then drive x=17, y=103 -> 2 cycles later char_out=2, glyph_x=1, glyph_y=3, in_row=1.
- Region boundaries:
  - x=127, y=109 -> in_row=1, char_out=15;
  - x=128 or y=110 or y=99 -> in_row=0, char_out=6'h3F.
- Auto write and wrap:
  - 17 auto writes of codes 0x20..0x30 -> col0=0x30, col1=0x21, col15=0x2F, wr_ptr=1.
- Clear:
  - pulse clr_req -> wr_ready low 16 cycles, then all columns read 0x3F and wr_ptr=0;
  - a write held valid during the sweep completes on the first IDLE cycle.
- Mid-sweep rst and edge writes:
  - rst at sweep cycle 5 -> INIT restarts, busy 16 more cycles;
  - explicit write wr_addr=3 on the same cycle as a lookup of col 3 -> old code returned, new code on the next lookup.
- With CHAR_ROW_CURSOR_EN, CURSOR_BLINK=2:
  - cursor_hit pulses over column wr_ptr;
  - toggles every 2 frame starts.
